dit_seq: RTL and testbench

DIT_SEQ -- requirements
Module: dit_seq

---
 rtl/dit_seq_if.sv | 27 ++
 rtl/dit_seq.sv | 114 +++++++++++
 tb/tb_dit_seq.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dit_seq_if.sv
// Streaming sample/result handshakes plus the FFT-core start/done bus used by dit_seq.
// master is the environment (sample source, FFT core, result sink); slave is dit_seq.
interface dit_seq_if #(
    parameter int DW = 17
);
    logic                in_valid;
    logic                in_ready;
    logic [DW-1:0]       in_data;
    logic                fft_start;
    logic [7:0][DW-1:0]  fft_samples;
    logic                fft_done;
    logic [15:0][DW-1:0] fft_result;
    logic                out_valid;
    logic                out_ready;
    logic [DW-1:0]       out_data;
    logic                out_last;

    modport master (
        output in_valid, in_data, fft_done, fft_result, out_ready,
        input  in_ready, fft_start, fft_samples, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, fft_done, fft_result, out_ready,
        output in_ready, fft_start, fft_samples, out_valid, out_data, out_last
    );
endinterface

// File: rtl/dit_seq.sv
// Frame sequencer around an 8-point DIT FFT core: gathers 8 samples, fires the core,
// waits (with timeout) for its 16 result words and streams them out one per handshake.
module dit_seq #(
    parameter int TIMEOUT = 64,
    parameter int DW      = 17
) (
    input  logic       clk,
    input  logic       reset,
    dit_seq_if.slave   bus,
    input  logic       err_clr,
    output logic       timeout_err,
    output logic [7:0] frame_cnt
);
    localparam int       NUM_SLOTS = 8;
    localparam int       NUM_WORDS = 16;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} state_t;

    state_t                      state, nxt;
    logic                        live;
    logic [2:0]                  ld_idx;
    logic [3:0]                  wr_idx;
    logic [7:0]                  timer;
    logic [NUM_SLOTS-1:0][DW-1:0] samples;
    logic [NUM_WORDS-1:0][DW-1:0] res;

    logic          rdy, start, ovld, olast;
    logic [DW-1:0] odata;
    logic          ld_fire, wr_fire, last_fire, to_hit, cap;

    assign ld_fire   = bus.in_valid && rdy;
    assign wr_fire   = ovld && bus.out_ready;
    assign last_fire = wr_fire && (wr_idx == 4'(NUM_WORDS - 1));
    assign cap       = (state == WAIT) && bus.fft_done;
    // done on the same cycle as the last timer value takes priority over the abort
    assign to_hit    = (state == WAIT) && !bus.fft_done && (timer == TO_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LOAD;
        else        state <= nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        nxt = state;
        case (state)
            LOAD:    if (ld_fire && ld_idx == 3'(NUM_SLOTS - 1)) nxt = START;
            START:   nxt = WAIT;
            WAIT:    if (bus.fft_done) nxt = DRAIN;
                     else if (timer == TO_LAST) nxt = LOAD;
            DRAIN:   if (last_fire) nxt = LOAD;
            default: nxt = LOAD;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        rdy   = live && (state == LOAD);
        start = (state == START);
        ovld  = (state == DRAIN);
        olast = (state == DRAIN) && (wr_idx == 4'(NUM_WORDS - 1));
        odata = (state == DRAIN) ? res[wr_idx] : '0;
    end

    // in_ready stays low while reset is held and rises on the first edge after release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) live <= 1'b0;
        else        live <= 1'b1;
    end

    // Sample slots only load in LOAD, so the core sees a stable vector through WAIT.
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        logic [DW-1:0] q;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)                          q <= '0;
            else if (ld_fire && ld_idx == 3'(i)) q <= bus.in_data;
        end
        assign samples[i] = q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_idx      <= '0;
            wr_idx      <= '0;
            timer       <= '0;
            res         <= '0;
            timeout_err <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            if (ld_fire)                   ld_idx <= ld_idx + 3'd1;
            else if (to_hit || last_fire)  ld_idx <= '0;

            if (state == WAIT && nxt == WAIT) timer <= timer + 8'd1;
            else                              timer <= '0;

            if (cap) res <= bus.fft_result;

            if (wr_fire) wr_idx <= last_fire ? 4'd0 : wr_idx + 4'd1;
            if (last_fire) frame_cnt <= frame_cnt + 8'd1;

            if (to_hit)       timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end

    assign bus.in_ready    = rdy;
    assign bus.fft_start   = start;
    assign bus.fft_samples = samples;
    assign bus.out_valid   = ovld;
    assign bus.out_last    = olast;
    assign bus.out_data    = odata;
endmodule

// File: tb/tb_dit_seq.sv
// Self-checking bench for dit_seq: table of frames plus hand sequences for timeout,
// err_clr priority, stray fft_done and mid-frame reset; results checked by a scoreboard.
module tb_dit_seq;
    localparam int DW      = 17;
    localparam int TIMEOUT = 64;
    localparam int CW      = 8 * DW;

    typedef logic [7:0][DW-1:0] frame_t;
    typedef struct {
        frame_t        smp;
        logic [DW-1:0] base;
        bit            respond;
        bit            stall;
        logic [7:0]    exp_cnt;
        bit            exp_err;
    } vec_t;
    typedef struct {
        logic [DW-1:0] data;
        bit            last;
    } word_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       err_clr = 1'b0;
    logic       timeout_err;
    logic [7:0] frame_cnt;

    dit_seq_if #(.DW(DW)) bus ();

    dit_seq #(.TIMEOUT(TIMEOUT), .DW(DW)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .err_clr(err_clr), .timeout_err(timeout_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_pass = 0;
    word_t exp_q[$];
    bit    core_respond = 1'b0;
    bit    stall_mode = 1'b0;
    logic  [DW-1:0] core_base = '0;
    logic  core_done = 1'b0;
    logic  spur_done = 1'b0;
    logic  [15:0][DW-1:0] result = '0;
    vec_t  vecs[4];

    assign bus.fft_done   = core_done | spur_done;
    assign bus.fft_result = result;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(input frame_t s, input logic [DW-1:0] b, input bit r,
                                 input bit st, input logic [7:0] c, input bit e);
        vec_t v;
        v.smp = s; v.base = b; v.respond = r; v.stall = st; v.exp_cnt = c; v.exp_err = e;
        return v;
    endfunction

    // FFT core model: result words base+0..base+15 with fft_done three cycles after start
    initial begin
        word_t w;
        logic [15:0][DW-1:0] r;
        forever begin
            @(negedge clk);
            if (bus.fft_start && core_respond) begin
                for (int i = 0; i < 16; i++) begin
                    w.data = core_base + DW'(i);
                    w.last = (i == 15);
                    r[i]   = w.data;
                    exp_q.push_back(w);
                end
                @(posedge clk); @(posedge clk); @(posedge clk); #1;
                result = r; core_done = 1'b1;
                @(posedge clk); #1;
                core_done = 1'b0;
            end
        end
    end

    // Result sink: random back-pressure when stall_mode is set
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard: pop on handshake, check hold against queue head while stalled
    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            if (reset && bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_word: got %0h expected none", bus.out_data);
                end else if (bus.out_ready) begin
                    w = exp_q.pop_front();
                    check("out_data", CW'(bus.out_data), CW'(w.data));
                    check("out_last", CW'(bus.out_last), CW'(w.last));
                end else begin
                    check("stall_hold", CW'(bus.out_data), CW'(exp_q[0].data));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    task automatic load(input frame_t s, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = s[i];
            for (int k = 0; k < 50 && !bus.in_ready; k++) step();
            if (!bus.in_ready) begin
                n_chk++;
                $display("FAIL in_ready_wait: got 0 expected 1");
            end
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_cnt(input logic [7:0] e);
        int k = 0;
        while (frame_cnt != e && k < 400) begin
            step();
            k++;
        end
        check("frame_cnt", CW'(frame_cnt), CW'(e));
    endtask

    task automatic run_vec(input vec_t v);
        core_respond = v.respond;
        core_base    = v.base;
        stall_mode   = v.stall;
        load(v.smp, 0, 8);
        check("fft_start_rise", CW'(bus.fft_start), 1);
        check("samples", bus.fft_samples, v.smp);
        check("cnt_before_drain", CW'(frame_cnt), CW'(v.respond ? v.exp_cnt - 8'd1 : v.exp_cnt));
        step();
        check("fft_start_pulse", CW'(bus.fft_start), 0);
        check("samples_hold", bus.fft_samples, v.smp);
        if (v.respond) begin
            step();
            check("samples_wait", bus.fft_samples, v.smp);
            wait_cnt(v.exp_cnt);
            check("in_ready_after", CW'(bus.in_ready), 1);
        end else begin
            repeat (TIMEOUT - 1) step();
            check("no_err_early", CW'(timeout_err), 0);
            check("still_wait", CW'(bus.in_ready), 0);
            step();
            check("timeout_err", CW'(timeout_err), 1);
            check("back_to_load", CW'(bus.in_ready), 1);
        end
        check("err_flag", CW'(timeout_err), CW'(v.exp_err));
        check("frame_cnt_end", CW'(frame_cnt), CW'(v.exp_cnt));
        check("queue_drained", CW'(exp_q.size()), 0);
        stall_mode = 1'b0;
    endtask

    initial begin
        frame_t fr;
        vecs[0] = mkv({17'd1125, 17'd6787, 17'd1056, 17'd5678, 17'd6785, 17'd6758, 17'd1156, 17'd1853},
                      17'd0, 1'b1, 1'b0, 8'd1, 1'b0);
        vecs[1] = mkv({17'd17, 17'd16, 17'd15, 17'd14, 17'd13, 17'd12, 17'd11, 17'd10},
                      17'h1000, 1'b1, 1'b1, 8'd2, 1'b0);
        vecs[2] = mkv({17'd28, 17'd27, 17'd26, 17'd25, 17'd24, 17'd23, 17'd22, 17'd21},
                      17'h2000, 1'b0, 1'b0, 8'd2, 1'b1);
        vecs[3] = mkv({17'd252, 17'd300, 17'd280, 17'd249, 17'd252, 17'd174, 17'd139, 17'd112},
                      17'h05A0, 1'b1, 1'b0, 8'd3, 1'b1);

        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // reset state
        step(); step();
        check("rst_in_ready", CW'(bus.in_ready), 0);
        check("rst_fft_start", CW'(bus.fft_start), 0);
        check("rst_out_valid", CW'(bus.out_valid), 0);
        check("rst_out_last", CW'(bus.out_last), 0);
        check("rst_err", CW'(timeout_err), 0);
        check("rst_cnt", CW'(frame_cnt), 0);
        check("rst_samples", bus.fft_samples, 0);
        #2 reset = 1'b1;
        step();
        check("in_ready_first_edge", CW'(bus.in_ready), 1);

        for (int v = 0; v < 4; v++) run_vec(vecs[v]);

        // err_clr drops the sticky flag
        err_clr = 1'b1; step(); err_clr = 1'b0;
        check("err_clr", CW'(timeout_err), 0);

        // timeout and err_clr on the same cycle: set wins
        core_respond = 1'b0;
        load(vecs[2].smp, 0, 8);
        step();
        repeat (TIMEOUT - 1) step();
        err_clr = 1'b1; step(); err_clr = 1'b0;
        check("err_set_wins", CW'(timeout_err), 1);
        check("set_wins_load", CW'(bus.in_ready), 1);

        // stray fft_done in LOAD and DRAIN
        fr = {17'd508, 17'd507, 17'd506, 17'd505, 17'd504, 17'd503, 17'd502, 17'd501};
        core_respond = 1'b1;
        core_base    = 17'h0300;
        load(fr, 0, 3);
        result = {16{17'h1ABCD}};
        spur_done = 1'b1; step(); spur_done = 1'b0;
        check("load_ignores_done", CW'(bus.in_ready), 1);
        check("load_no_out", CW'(bus.out_valid), 0);
        load(fr, 3, 8);
        check("samples_after_stray", bus.fft_samples, fr);
        for (int k = 0; k < 20 && !bus.out_valid; k++) step();
        step(); step(); step();
        result = {16{17'h0DEAD}};
        spur_done = 1'b1; step(); spur_done = 1'b0;
        check("drain_ignores_done", CW'(bus.out_valid), 1);
        wait_cnt(8'd4);

        // reset after the 5th sample discards the partial frame
        core_base = 17'h7000;
        fr = {17'd608, 17'd607, 17'd606, 17'd605, 17'd604, 17'd603, 17'd602, 17'd601};
        load(fr, 0, 5);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_in_ready", CW'(bus.in_ready), 0);
        check("mid_rst_cnt", CW'(frame_cnt), 0);
        check("mid_rst_err", CW'(timeout_err), 0);
        check("mid_rst_samples", bus.fft_samples, 0);
        check("mid_rst_out_data", CW'(bus.out_data), 0);
        step();
        #2 reset = 1'b1;
        step();
        check("post_rst_in_ready", CW'(bus.in_ready), 1);
        run_vec(mkv({17'd708, 17'd707, 17'd706, 17'd705, 17'd704, 17'd703, 17'd702, 17'd701},
                    17'h7000, 1'b1, 1'b0, 8'd1, 1'b0));

        repeat (3) step();
        check("final_queue", CW'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
